shift_arbiter: RTL and testbench

- Shares one Barrel_Shifter instance between two independent requesters (req0, req1).
- Uses valid/ready handshakes on both the request and response sides.
- Arbitrates round-robin, latches the winning operands, drives the shared shifter and returns a tagged result.
- Keeps at most one operation in flight. Sits between the ALU-side issue logic and the Barrel_Shifter datapath.

---
 rtl/shift_arbiter_pkg.sv | 15 +
 rtl/Barrel_Shifter.sv | 37 +++
 rtl/rr_arb2.sv | 27 ++
 rtl/shift_arbiter.sv | 115 +++++++++++
 tb/tb_shift_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_arbiter_pkg.sv
// ---- shift_arbiter_pkg : shared encodings and default widths | rev 1.0 ----
`default_nettype none

package shift_arbiter_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SHAMT_W = 5;
endpackage

`default_nettype wire

// File: rtl/Barrel_Shifter.sv
// ---- Barrel_Shifter : log-stage shifter, 1 = arithmetic right, 0 = logical left | rev 1.0 ----
`default_nettype none

module Barrel_Shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Direction,
  input  logic [SHAMT_W-1:0] Amount,
  input  logic [DATA_W-1:0]  INPUT,
  output logic [DATA_W-1:0]  OUTPUT
);
  // Stage i shifts by 2**i when Amount[i] is set.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int SH = 1 << i;
    logic [DATA_W-1:0] w_prev;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_res;

    if (i == 0) begin : g_first
      assign w_prev = INPUT;
    end else begin : g_chain
      assign w_prev = g_stage[i-1].w_res;
    end

    always_comb begin
      if (Direction) w_shifted = DATA_W'($signed(w_prev) >>> SH);
      else           w_shifted = w_prev << SH;
    end

    assign w_res = Amount[i] ? w_shifted : w_prev;
  end

  assign OUTPUT = g_stage[SHAMT_W-1].w_res;
endmodule

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---- rr_arb2 : two-input round-robin grant with pointer update | rev 1.0 ----
`default_nettype none

module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant,
  output logic any
);
  logic r_ptr;

  always_comb begin
    any   = valid0 | valid1;
    grant = (valid0 && valid1) ? r_ptr : valid1;
  end

  // The loser of this grant gets priority next time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_ptr <= 1'b0;
    else if (advance) r_ptr <= ~grant;
  end
endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ---- shift_arbiter : round-robin sharing of one Barrel_Shifter by two requesters | rev 1.0 ----
`default_nettype none

module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic               req0_dir,
  input  logic [SHAMT_W-1:0] req0_amt,
  input  logic [DATA_W-1:0]  req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic               req1_dir,
  input  logic [SHAMT_W-1:0] req1_amt,
  input  logic [DATA_W-1:0]  req1_data,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_data,
  input  logic               rsp_ready,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
);
  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic               w_accept_ok;
  logic               w_accept;
  logic               w_grant;
  logic               w_any;
  logic               r_dir;
  logic [SHAMT_W-1:0] r_amt;
  logic [DATA_W-1:0]  r_data;
  logic               r_id;
  logic [CNT_W-1:0]   r_cnt0;
  logic [CNT_W-1:0]   r_cnt1;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .advance (w_accept),
    .grant   (w_grant),
    .any     (w_any)
  );

  // Reset gates acceptance so no ready escapes while the async reset is held.
  always_comb begin
    w_accept_ok = !reset && ((r_state == IDLE) || (r_state == HOLD && rsp_ready));
    w_accept    = w_accept_ok && w_any;
    req0_ready  = w_accept && !w_grant;
    req1_ready  = w_accept && w_grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)                          w_state_nxt = HOLD;
    else if (r_state == HOLD && rsp_ready) w_state_nxt = IDLE;
  end

  always_comb begin
    rsp_valid = (r_state == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir  <= DIR_LEFT;
      r_amt  <= '0;
      r_data <= '0;
      r_id   <= 1'b0;
    end else if (w_accept) begin
      r_dir  <= w_grant ? req1_dir  : req0_dir;
      r_amt  <= w_grant ? req1_amt  : req0_amt;
      r_data <= w_grant ? req1_data : req0_data;
      r_id   <= w_grant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_accept) begin
      if (!w_grant && r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if ( w_grant && r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  Barrel_Shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .Direction (r_dir),
    .Amount    (r_amt),
    .INPUT     (r_data),
    .OUTPUT    (rsp_data)
  );

  assign rsp_id     = r_id;
  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ---- tb_shift_arbiter : scoreboard bench for shift_arbiter | rev 1.0 ----
`default_nettype none

module tb_shift_arbiter;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_dir, req0_ready;
  logic [SW-1:0] req0_amt;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_dir, req1_ready;
  logic [SW-1:0] req1_amt;
  logic [DW-1:0] req1_data;
  logic          rsp_valid, rsp_id, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  shift_arbiter #(.DATA_W(DW), .SHAMT_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_amt(req0_amt),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_amt(req1_amt),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW:0]   sb_q[$];
  logic          m_hold;
  logic          m_ptr;
  logic [CW-1:0] m_cnt0, m_cnt1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_shift(input logic dir, input logic [SW-1:0] amt,
                                              input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) begin
      if (dir) r[i] = (i + int'(amt) < DW) ? d[i + int'(amt)] : d[DW-1];
      else     r[i] = (i >= int'(amt)) ? d[i - int'(amt)] : 1'b0;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_hold = 1'b0; m_ptr = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
    sb_q.delete();
  endtask

  // Check at the falling edge, then advance the model across the next rising edge.
  task automatic cycle();
    logic acc_ok, g, e0, e1;
    @(negedge clk);
    acc_ok = !m_hold || rsp_ready;
    g  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
    e0 = acc_ok && req0_valid && !g;
    e1 = acc_ok && req1_valid && g;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_hold));
    chk("cnt0", 32'(grant_cnt0), 32'(m_cnt0));
    chk("cnt1", 32'(grant_cnt1), 32'(m_cnt1));
    if (m_hold && sb_q.size() > 0) begin
      chk("rsp_id",   32'(rsp_id), 32'(sb_q[0][DW]));
      chk("rsp_data", rsp_data,    sb_q[0][DW-1:0]);
      if (rsp_ready) void'(sb_q.pop_front());
    end
    if (e0 || e1) begin
      sb_q.push_back({g, g ? ref_shift(req1_dir, req1_amt, req1_data)
                           : ref_shift(req0_dir, req0_amt, req0_data)});
      m_ptr  = ~g;
      if (!g && m_cnt0 != '1) m_cnt0 = m_cnt0 + 1'b1;
      if ( g && m_cnt1 != '1) m_cnt1 = m_cnt1 + 1'b1;
      m_hold = 1'b1;
    end else if (m_hold && rsp_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic d, input logic [SW-1:0] a, input logic [DW-1:0] x);
    req0_valid = v; req0_dir = d; req0_amt = a; req0_data = x;
  endtask

  task automatic set1(input logic v, input logic d, input logic [SW-1:0] a, input logic [DW-1:0] x);
    req1_valid = v; req1_dir = d; req1_amt = a; req1_data = x;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    model_clear();
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  logic          bd_dir [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [SW-1:0] bd_amt [5] = '{5'd0, 5'd31, 5'd31, 5'd0, 5'd31};
  logic [DW-1:0] bd_dat [5] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000001, 32'h00000001};
  logic [DW-1:0] bd_exp [5] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h80000000};

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    set0(1'b1, 1'b0, '0, '0);
    set1(1'b1, 1'b0, '0, '0);
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_vld",  32'(rsp_valid),  32'd0);
    chk("rst_id",   32'(rsp_id),     32'd0);
    chk("rst_data", rsp_data,        32'd0);
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single request from req0
    set0(1'b1, 1'b1, 5'd4, 32'h80000000);
    cycle();
    set0(1'b0, 1'b0, '0, '0);
    #3;
    chk("t1_data", rsp_data, 32'hF8000000);
    chk("t1_cnt0", 32'(grant_cnt0), 32'd1);
    cycle();
    rsp_ready = 1'b1;
    cycle();

    // Both valid continuously, streaming
    set0(1'b1, 1'b0, 5'd3, 32'h00000001);
    set1(1'b1, 1'b1, 5'd1, 32'h40000000);
    repeat (8) cycle();

    // Backpressure with both still pending
    rsp_ready = 1'b0;
    repeat (5) cycle();
    rsp_ready = 1'b1;
    repeat (3) cycle();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    cycle();

    // Boundary amounts
    for (int i = 0; i < 5; i++) begin
      set0(1'b1, bd_dir[i], bd_amt[i], bd_dat[i]);
      cycle();
      set0(1'b0, 1'b0, '0, '0);
      #3;
      chk("bnd_data", rsp_data, bd_exp[i]);
      cycle();
    end

    // Async reset while holding a result
    rsp_ready = 1'b0;
    set1(1'b1, 1'b0, 5'd2, 32'h00000003);
    cycle();
    cycle();
    #2;
    reset = 1'b1;
    set0(1'b1, 1'b0, 5'd1, 32'h00000005);
    #1;
    chk("ar_vld",  32'(rsp_valid),  32'd0);
    chk("ar_data", rsp_data,        32'd0);
    chk("ar_cnt0", 32'(grant_cnt0), 32'd0);
    chk("ar_cnt1", 32'(grant_cnt1), 32'd0);
    chk("ar_rdy0", 32'(req0_ready), 32'd0);
    chk("ar_rdy1", 32'(req1_ready), 32'd0);
    model_clear();
    @(posedge clk); #3;
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_grant0", 32'(req0_ready), 32'd1);
    cycle();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    cycle();

    // Counter saturation on req1
    do_reset();
    set1(1'b1, 1'b1, 5'd1, 32'h12345678);
    repeat (20) cycle();
    set1(1'b0, 1'b0, '0, '0);
    cycle();
    chk("sat_cnt1", 32'(grant_cnt1), 32'd15);
    chk("sat_cnt0", 32'(grant_cnt0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
